// File: rtl/nios_pio_rx_fifo.sv
// nios_pio_rx_fifo
// Receive stage behind the Nios 32-bit output PIO. Bit 31 of the PIO word is a
// toggle strobe. Each toggle pushes bits 30:0 into a small first-word
// fall-through FIFO, which is presented on a valid/ready interface. The toggle
// of the last accepted word is returned on ack_toggle for software flow control.
module nios_pio_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pio_in,
   output logic [30:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ack_toggle,
   output logic             overflow,
   input  logic             clr_overflow,
   output logic [LVL_W-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]      r_pio_q;
   logic             r_prev_tog;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             r_ack;
   logic             r_ovf;
   logic [30:0]      r_mem [DEPTH];

   logic w_event;
   logic w_full;
   logic w_pop;
   logic w_push;

   // Event detection and push/pop qualification
   always_comb begin
      w_event = (r_pio_q[31] != r_prev_tog);
      w_full  = (r_level == LVL_W'(DEPTH));
      w_pop   = (r_level != '0) && out_ready;
      // A pop in the same cycle frees a slot, so a push into a full FIFO is allowed
      w_push  = w_event && (!w_full || w_pop);
   end

   // Input capture, toggle tracking, pointers, occupancy, ack and overflow state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pio_q    <= '0;
         r_prev_tog <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_ack      <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_pio_q <= pio_in;

         if (w_event) begin
            r_prev_tog <= r_pio_q[31];
         end

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_ack    <= r_pio_q[31];
         end

         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end

         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase

         // A dropped word takes priority over a same-cycle clear
         if (w_event && !w_push) begin
            r_ovf <= 1'b1;
         end else if (clr_overflow) begin
            r_ovf <= 1'b0;
         end
      end
   end

   // FIFO storage; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= r_pio_q[30:0];
      end
   end

   // Outputs come from registers only
   always_comb begin
      out_data   = r_mem[r_rd_ptr];
      out_valid  = (r_level != '0);
      level      = r_level;
      ack_toggle = r_ack;
      overflow   = r_ovf;
   end

endmodule

// File: tb/tb_nios_pio_rx_fifo.sv
// Self-checking bench for nios_pio_rx_fifo with a payload scoreboard.
module tb_nios_pio_rx_fifo;

   localparam int DEPTH = 4;
   localparam int LVL_W = 3;

   logic             clk;
   logic             reset;
   logic [31:0]      pio_in;
   logic [30:0]      out_data;
   logic             out_valid;
   logic             out_ready;
   logic             ack_toggle;
   logic             overflow;
   logic             clr_overflow;
   logic [LVL_W-1:0] level;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [30:0] sb_q[$];
   logic        tog;
   logic        ack_exp;

   nios_pio_rx_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .pio_in      (pio_in),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ack_toggle  (ack_toggle),
      .overflow    (overflow),
      .clr_overflow(clr_overflow),
      .level       (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Flip the strobe and present a new payload; optionally expect it to be accepted
   task automatic send(input logic [30:0] payload, input bit accepted);
      tog    = ~tog;
      pio_in = {tog, payload};
      if (accepted) sb_q.push_back(payload);
   endtask

   // Every pop seen by the DUT is checked against the scoreboard head
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_pop", {1'b0, out_data}, 32'hFFFF_FFFF);
         end else begin
            check_eq("pop_data", {1'b0, out_data}, {1'b0, sb_q.pop_front()});
         end
      end
   end

   initial begin
      reset        = 1'b1;
      pio_in       = '0;
      out_ready    = 1'b0;
      clr_overflow = 1'b0;
      tog          = 1'b0;
      ack_exp      = 1'b0;

      // Reset
      repeat (3) tick();
      reset = 1'b0;
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_level", 32'(level), 32'd0);
      check_eq("rst_ack", 32'(ack_toggle), 32'd0);
      check_eq("rst_ovf", 32'(overflow), 32'd0);

      // Payload change without toggle is ignored
      pio_in = 32'h0000_1234;
      repeat (3) tick();
      check_eq("nochg_level", 32'(level), 32'd0);
      check_eq("nochg_valid", 32'(out_valid), 32'd0);

      // Single word, two-cycle latency
      send(31'h0AB, 1'b1);
      tick();
      check_eq("lat_not_yet", 32'(out_valid), 32'd0);
      tick();
      check_eq("single_valid", 32'(out_valid), 32'd1);
      check_eq("single_data", {1'b0, out_data}, 32'h0000_00AB);
      check_eq("single_ack", 32'(ack_toggle), 32'd1);
      check_eq("single_level", 32'(level), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("single_popped", 32'(level), 32'd0);

      // Fill and overflow: payload 5 is dropped
      for (int i = 1; i <= 5; i++) begin
         send(31'(i), i <= 4);
         if (i == 4) ack_exp = tog;
         tick();
      end
      tick();
      check_eq("fill_level", 32'(level), 32'd4);
      check_eq("fill_ovf", 32'(overflow), 32'd1);
      check_eq("fill_ack", 32'(ack_toggle), 32'(ack_exp));
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      repeat (2) tick();
      check_eq("drain_level", 32'(level), 32'd0);
      check_eq("drain_valid", 32'(out_valid), 32'd0);
      check_eq("drain_sb", 32'(sb_q.size()), 32'd0);

      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check_eq("clr_ovf", 32'(overflow), 32'd0);

      // Full FIFO, push and pop on the same edge
      for (int i = 0; i < 4; i++) begin
         send(31'h11 + 31'(i), 1'b1);
         tick();
      end
      tick();
      check_eq("full_level", 32'(level), 32'd4);
      send(31'h9, 1'b1);
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("pushpop_level", 32'(level), 32'd4);
      check_eq("pushpop_ovf", 32'(overflow), 32'd0);
      check_eq("pushpop_ack", 32'(ack_toggle), 32'(tog));
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      check_eq("pushpop_drained", 32'(level), 32'd0);

      // Sustained one word per cycle
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(31'h4000_0000 | 31'(i * 7), 1'b1);
         tick();
      end
      repeat (3) tick();
      out_ready = 1'b0;
      check_eq("stream_ovf", 32'(overflow), 32'd0);
      check_eq("stream_level", 32'(level), 32'd0);

      // Drop coinciding with clear: set wins
      for (int i = 0; i < 4; i++) begin
         send(31'h21 + 31'(i), 1'b1);
         tick();
      end
      ack_exp = tog;
      send(31'h25, 1'b0);
      tick();
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check_eq("setclr_ovf", 32'(overflow), 32'd1);
      check_eq("drop_ack", 32'(ack_toggle), 32'(ack_exp));
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check_eq("clr_alone", 32'(overflow), 32'd0);

      // Reset mid-operation
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("mid_level3", 32'(level), 32'd3);
      pio_in = '0;
      tog    = 1'b0;
      reset  = 1'b1;
      tick();
      reset  = 1'b0;
      sb_q.delete();
      check_eq("mid_rst_level", 32'(level), 32'd0);
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_ack", 32'(ack_toggle), 32'd0);
      tick();
      check_eq("mid_rst_noevt", 32'(level), 32'd0);
      send(31'h77, 1'b1);
      repeat (2) tick();
      check_eq("post_rst_level", 32'(level), 32'd1);
      check_eq("post_rst_ack", 32'(ack_toggle), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      repeat (2) tick();
      check_eq("post_rst_once", 32'(level), 32'd0);
      check_eq("final_sb", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
